// File: rtl/sr_pkg.sv
// Shared definitions for the SR flip-flop bank: conflict resolution modes
// and the per-channel request pair.
package sr_pkg;

  // Resolution of a simultaneous set and reset request
  localparam int unsigned CONF_HOLD = 0;
  localparam int unsigned CONF_SET  = 1;
  localparam int unsigned CONF_RST  = 2;
  localparam int unsigned CONF_TOG  = 3;

  // One channel's request pair
  typedef struct packed {
    logic s;
    logic r;
  } sr_req_t;

endpackage

// File: rtl/sr_ff_cell.sv
// Single clocked SR channel with configurable resolution of s=r=1.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset, loads RST_VAL
//   en   - update enable; state holds when low
//   req  - set/reset request pair
//   q    - registered channel state
module sr_ff_cell
  import sr_pkg::*;
#(
  parameter int unsigned CONF_MODE = CONF_HOLD,
  parameter logic        RST_VAL   = 1'b0
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    en,
  input  sr_req_t req,
  output logic    q
);

  // Next state for a conflicting request, fixed by CONF_MODE
  logic conf_next;

  always_comb begin
    conf_next = q;
    if (CONF_MODE == CONF_SET) begin
      conf_next = 1'b1;
    end else if (CONF_MODE == CONF_RST) begin
      conf_next = 1'b0;
    end else if (CONF_MODE == CONF_TOG) begin
      conf_next = ~q;
    end
  end

  // Channel state register
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (en) begin
      case ({req.s, req.r})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= conf_next;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/sr_ff_bank.sv
// Bank of WIDTH clocked set/reset flip-flops with sticky conflict flags and
// a saturating count of cycles that saw at least one s=r=1 conflict.
// Optional build macro SR_EDGE_EN: requests act on the rising edge of s/r
// (inputs registered internally while en=1) instead of on their level.
// Ports:
//   clk          - rising-edge clock
//   rst          - synchronous active-high reset
//   en           - global update enable
//   s, r         - per-channel set / reset requests
//   clr_err      - synchronous clear of conflict flags and counter
//   q, q_n       - channel state and its inverse (q_n combinational)
//   conflict     - sticky per-channel conflict flags
//   conflict_cnt - saturating conflict cycle count
module sr_ff_bank
  import sr_pkg::*;
#(
  parameter int unsigned       WIDTH     = 8,
  parameter int unsigned       CONF_MODE = CONF_HOLD,
  parameter int unsigned       CNT_W     = 8,
  parameter logic [WIDTH-1:0]  RST_VAL   = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic [WIDTH-1:0] conflict,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Configuration sanity
  if (CONF_MODE > CONF_TOG) begin : g_bad_conf_mode
    $error("sr_ff_bank: CONF_MODE %0d out of range 0..3", CONF_MODE);
  end
  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("sr_ff_bank: WIDTH %0d out of range 1..64", WIDTH);
  end

  logic [WIDTH-1:0] s_eff;
  logic [WIDTH-1:0] r_eff;

`ifdef SR_EDGE_EN
  logic [WIDTH-1:0] s_d;
  logic [WIDTH-1:0] r_d;

  // Previous request levels; only advance on enabled cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      s_d <= '0;
      r_d <= '0;
    end else if (en) begin
      s_d <= s;
      r_d <= r;
    end
  end

  assign s_eff = s & ~s_d;
  assign r_eff = r & ~r_d;
`else
  assign s_eff = s;
  assign r_eff = r;
`endif

  // Channels
  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_ch
    sr_req_t req;
    assign req = '{s: s_eff[i], r: r_eff[i]};

    sr_ff_cell #(
      .CONF_MODE (CONF_MODE),
      .RST_VAL   (RST_VAL[i])
    ) u_cell (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .req (req),
      .q   (q[i])
    );
  end

  assign q_n = ~q;

  logic [WIDTH-1:0] conf_now;
  assign conf_now = en ? (s_eff & r_eff) : '0;

  // Sticky flags and saturating counter; clr_err beats a same-cycle conflict
  always_ff @(posedge clk) begin
    if (rst || clr_err) begin
      conflict     <= '0;
      conflict_cnt <= '0;
    end else begin
      conflict <= conflict | conf_now;
      if ((|conf_now) && (conflict_cnt != CNT_MAX)) begin
        conflict_cnt <= conflict_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sr_ff_bank.sv
// Self-checking bench: five bank instances (all conflict modes, several
// counter widths, a WIDTH=1 corner) share one stimulus stream and are
// compared every cycle against a bit-level reference model.
module tb_sr_ff_bank;

  localparam int NI = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [7:0] s = '0;
  logic [7:0] r = '0;
  logic       clr_err = 1'b0;

  always #5 clk = ~clk;

  // Per-instance configuration, mirrored by the model
  int         cfg_mode [NI] = '{0, 1, 2, 3, 3};
  int         cfg_cntw [NI] = '{2, 8, 3, 8, 2};
  logic [7:0] cfg_mask [NI] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01};
  logic [7:0] cfg_rstv [NI] = '{8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h01};

  logic [7:0] q_0, qn_0, cf_0; logic [1:0] cnt_0;
  logic [7:0] q_1, qn_1, cf_1; logic [7:0] cnt_1;
  logic [7:0] q_2, qn_2, cf_2; logic [2:0] cnt_2;
  logic [7:0] q_3, qn_3, cf_3; logic [7:0] cnt_3;
  logic       q_4, qn_4, cf_4; logic [1:0] cnt_4;

  sr_ff_bank #(.WIDTH(8), .CONF_MODE(0), .CNT_W(2), .RST_VAL(8'h0F)) u_m0 (
    .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .clr_err(clr_err),
    .q(q_0), .q_n(qn_0), .conflict(cf_0), .conflict_cnt(cnt_0));
  sr_ff_bank #(.WIDTH(8), .CONF_MODE(1), .CNT_W(8), .RST_VAL(8'h0F)) u_m1 (
    .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .clr_err(clr_err),
    .q(q_1), .q_n(qn_1), .conflict(cf_1), .conflict_cnt(cnt_1));
  sr_ff_bank #(.WIDTH(8), .CONF_MODE(2), .CNT_W(3), .RST_VAL(8'h0F)) u_m2 (
    .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .clr_err(clr_err),
    .q(q_2), .q_n(qn_2), .conflict(cf_2), .conflict_cnt(cnt_2));
  sr_ff_bank #(.WIDTH(8), .CONF_MODE(3), .CNT_W(8), .RST_VAL(8'h0F)) u_m3 (
    .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .clr_err(clr_err),
    .q(q_3), .q_n(qn_3), .conflict(cf_3), .conflict_cnt(cnt_3));
  sr_ff_bank #(.WIDTH(1), .CONF_MODE(3), .CNT_W(2), .RST_VAL(1'b1)) u_w1 (
    .clk(clk), .rst(rst), .en(en), .s(s[0]), .r(r[0]), .clr_err(clr_err),
    .q(q_4), .q_n(qn_4), .conflict(cf_4), .conflict_cnt(cnt_4));

  logic [7:0] dq [NI];
  logic [7:0] dqn [NI];
  logic [7:0] dcf [NI];
  logic [7:0] dcnt [NI];

  assign dq[0] = q_0;  assign dqn[0] = qn_0;  assign dcf[0] = cf_0;  assign dcnt[0] = 8'(cnt_0);
  assign dq[1] = q_1;  assign dqn[1] = qn_1;  assign dcf[1] = cf_1;  assign dcnt[1] = cnt_1;
  assign dq[2] = q_2;  assign dqn[2] = qn_2;  assign dcf[2] = cf_2;  assign dcnt[2] = 8'(cnt_2);
  assign dq[3] = q_3;  assign dqn[3] = qn_3;  assign dcf[3] = cf_3;  assign dcnt[3] = cnt_3;
  assign dq[4] = 8'(q_4); assign dqn[4] = 8'(qn_4); assign dcf[4] = 8'(cf_4); assign dcnt[4] = 8'(cnt_4);

  // Reference model state
  logic [7:0] mq [NI];
  logic [7:0] mcf [NI];
  int         mcnt [NI];
  logic [7:0] msd [NI];
  logic [7:0] mrd [NI];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Apply one clock edge's worth of behaviour to every modelled instance
  task automatic model_update();
    for (int k = 0; k < NI; k++) begin
      logic [7:0] sm, rm, se, re, cf;
      sm = s & cfg_mask[k];
      rm = r & cfg_mask[k];
      if (rst) begin
        mq[k] = cfg_rstv[k]; mcf[k] = '0; mcnt[k] = 0; msd[k] = '0; mrd[k] = '0;
      end else if (en) begin
`ifdef SR_EDGE_EN
        se = sm & ~msd[k];
        re = rm & ~mrd[k];
`else
        se = sm;
        re = rm;
`endif
        cf = se & re;
        for (int b = 0; b < 8; b++) begin
          if (se[b] && re[b]) begin
            case (cfg_mode[k])
              1: mq[k][b] = 1'b1;
              2: mq[k][b] = 1'b0;
              3: mq[k][b] = ~mq[k][b];
              default: ;
            endcase
          end else if (se[b]) mq[k][b] = 1'b1;
          else if (re[b]) mq[k][b] = 1'b0;
        end
        if (clr_err) begin
          mcf[k] = '0; mcnt[k] = 0;
        end else begin
          mcf[k] |= cf;
          if (cf != 0 && mcnt[k] < (1 << cfg_cntw[k]) - 1) mcnt[k]++;
        end
        msd[k] = sm;
        mrd[k] = rm;
      end else if (clr_err) begin
        mcf[k] = '0; mcnt[k] = 0;
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NI; k++) begin
      check($sformatf("i%0d_q", k),    64'(dq[k]),   64'(mq[k]));
      check($sformatf("i%0d_qn", k),   64'(dqn[k]),  64'(~mq[k] & cfg_mask[k]));
      check($sformatf("i%0d_conf", k), 64'(dcf[k]),  64'(mcf[k]));
      check($sformatf("i%0d_cnt", k),  64'(dcnt[k]), 64'(mcnt[k]));
    end
  endtask

  task automatic step(input logic rst_i, input logic en_i, input logic [7:0] s_i,
                      input logic [7:0] r_i, input logic clr_i);
    rst = rst_i; en = en_i; s = s_i; r = r_i; clr_err = clr_i;
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      mq[k] = '0; mcf[k] = '0; mcnt[k] = 0; msd[k] = '0; mrd[k] = '0;
    end

    // Reset with all sets requested
    step(1, 1, 8'hFF, 8'h00, 0);
    check("rst_q_const", 64'(q_0), 64'h0F);
    check("rst_cnt_const", 64'(cnt_1), 64'h0);

    // Basic set/reset and enable hold
    step(0, 1, 8'h05, 8'h00, 0);
    check("set_q_const", 64'(q_1), 64'h0F);
    step(1, 0, 8'h00, 8'h00, 0);
    step(0, 1, 8'h00, 8'hFF, 0);
    step(0, 1, 8'h05, 8'h00, 0);
    check("set05_const", 64'(q_2), 64'h05);
    step(0, 1, 8'h00, 8'h01, 0);
    step(0, 1, 8'h00, 8'h00, 0);
    step(0, 0, 8'hF0, 8'h00, 0);
    check("en_hold_const", 64'(q_2), 64'h04);

    // Conflict on channel 0 for three edges starting from q=0
    step(0, 1, 8'h00, 8'hFF, 0);
    step(0, 1, 8'h00, 8'h00, 1);
    repeat (3) step(0, 1, 8'h01, 8'h01, 0);
    step(0, 1, 8'h00, 8'h00, 0);

    // Saturation with channels 0 and 3 conflicting together
    step(0, 1, 8'h00, 8'h00, 1);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 8'h09, 8'h09, 0);
      step(0, 1, 8'h00, 8'h00, 0);
    end
    check("sat_conf_const", 64'(cf_0), 64'h09);
    check("sat_cnt_const", 64'(cnt_0), 64'h3);
    step(0, 1, 8'h09, 8'h09, 1);
    check("clr_wins_const", 64'(cnt_1), 64'h0);

    // Reset mid-operation, then release with s held
    step(0, 1, 8'h01, 8'h01, 0);
    step(1, 1, 8'hFF, 8'h00, 0);
    step(0, 1, 8'hFF, 8'h00, 0);

    // Held s[2] followed by an r[2] pulse, then s[2] reasserted
    step(0, 1, 8'h00, 8'hFF, 0);
    step(0, 1, 8'h00, 8'h00, 0);
    repeat (4) step(0, 1, 8'h04, 8'h00, 0);
    step(0, 1, 8'h00, 8'h04, 0);
    step(0, 1, 8'h04, 8'h00, 0);
    step(0, 1, 8'h04, 8'h00, 0);

    // Randomised traffic
    for (int i = 0; i < 800; i++) begin
      logic       rr, ee, cc;
      logic [7:0] ss, rv;
      rr = ($urandom_range(0, 63) == 0);
      ee = ($urandom_range(0, 7) != 0);
      cc = ($urandom_range(0, 15) == 0);
      ss = 8'($urandom) & 8'($urandom);
      rv = 8'($urandom) & 8'($urandom);
      if ($urandom_range(0, 7) == 0) rv = ss;
      step(rr, ee, ss, rv, cc);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
